// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, flag bit positions and FSM
// state encoding for the arbitrated ALU.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_NOT = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_OR  = 3'd4;
   localparam logic [2:0] OP_XOR = 3'd5;
   localparam logic [2:0] OP_MUL = 3'd6;
   localparam logic [2:0] OP_DIV = 3'd7;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/alu.sv
// alu: single-cycle combinational datapath; carry is
// ADD carry-out, SUB borrow or MUL high-half nonzero.
module alu
   import alu_pkg::*;
#(
   parameter int WORD_SIZE = 16,
   parameter int OP_SIZE   = 3
) (
   input  logic [OP_SIZE-1:0]   op_i,
   input  logic [WORD_SIZE-1:0] a_i,
   input  logic [WORD_SIZE-1:0] b_i,
   output logic [WORD_SIZE-1:0] res_o,
   output logic                 carry_o
);

   logic [WORD_SIZE:0]     sum;
   logic [2*WORD_SIZE-1:0] prod;

   assign sum  = {1'b0, a_i} + {1'b0, b_i};
   assign prod = {{WORD_SIZE{1'b0}}, a_i} * {{WORD_SIZE{1'b0}}, b_i};

   // opcode decode; divide guarded so b == 0 never yields X
   always_comb begin
      res_o   = '0;
      carry_o = 1'b0;
      unique case (op_i)
         OP_ADD: begin
            res_o   = sum[WORD_SIZE-1:0];
            carry_o = sum[WORD_SIZE];
         end
         OP_SUB: begin
            res_o   = a_i - b_i;
            carry_o = a_i < b_i;
         end
         OP_NOT: res_o = ~a_i;
         OP_AND: res_o = a_i & b_i;
         OP_OR:  res_o = a_i | b_i;
         OP_XOR: res_o = a_i ^ b_i;
         OP_MUL: begin
            res_o   = prod[WORD_SIZE-1:0];
            carry_o = |prod[2*WORD_SIZE-1:WORD_SIZE];
         end
         OP_DIV: res_o = (b_i == '0) ? '1 : a_i / b_i;
         default: res_o = '0;
      endcase
   end

endmodule

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector; the index
// just after last_grant has highest priority.
module rr_pick #(
   parameter int NUM_REQ = 2,
   localparam int ID_W = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [ID_W-1:0]    last_grant,
   output logic [NUM_REQ-1:0] grant_oh,
   output logic [ID_W-1:0]    grant_idx,
   output logic               any_valid
);

   int idx;

   // scan from last_grant+1 upward, wrapping, first hit wins
   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      any_valid = 1'b0;
      idx       = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last_grant) + k) % NUM_REQ;
         if (!any_valid && valid[idx]) begin
            any_valid     = 1'b1;
            grant_idx     = ID_W'(idx);
            grant_oh[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between
// NUM_REQ requesters with a registered response channel.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WORD_SIZE = 16,
   parameter int OP_SIZE   = 3,
   parameter int NUM_REQ   = 2,
   parameter int ID_W      = $clog2(NUM_REQ)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*OP_SIZE-1:0]   req_op,
   input  logic [NUM_REQ*WORD_SIZE-1:0] req_a,
   input  logic [NUM_REQ*WORD_SIZE-1:0] req_b,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [ID_W-1:0]              rsp_id,
   output logic [WORD_SIZE-1:0]         rsp_data,
   output logic [3:0]                   rsp_flags,
   output logic                         busy
);

   state_e                 state_q, state_d;
   logic [ID_W-1:0]        last_q, last_d;
   logic [ID_W-1:0]        id_q, id_d;
   logic [OP_SIZE-1:0]     op_q, op_d;
   logic [WORD_SIZE-1:0]   a_q, a_d, b_q, b_d;
   logic [WORD_SIZE-1:0]   data_q, data_d;
   logic [3:0]             flags_q, flags_d;

   logic [NUM_REQ-1:0]     gnt_oh;
   logic [ID_W-1:0]        gnt_idx;
   logic                   any_v;
   logic [WORD_SIZE-1:0]   alu_res;
   logic                   alu_c;
   logic                   div0;
   logic [WORD_SIZE-1:0]   res;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .valid      (req_valid),
      .last_grant (last_q),
      .grant_oh   (gnt_oh),
      .grant_idx  (gnt_idx),
      .any_valid  (any_v)
   );

   alu #(.WORD_SIZE(WORD_SIZE), .OP_SIZE(OP_SIZE)) u_alu (
      .op_i    (op_q),
      .a_i     (a_q),
      .b_i     (b_q),
      .res_o   (alu_res),
      .carry_o (alu_c)
   );

   assign div0 = (op_q == OP_SIZE'(OP_DIV)) && (b_q == '0);
   assign res  = div0 ? '1 : alu_res;

   assign rsp_id    = id_q;
   assign rsp_data  = data_q;
   assign rsp_flags = flags_q;
   assign busy      = state_q != IDLE;

   // next-state, grant and response-register capture
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      id_d      = id_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      data_d    = data_q;
      flags_d   = flags_q;
      req_ready = '0;
      rsp_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (any_v) begin
               req_ready = gnt_oh;
               id_d      = gnt_idx;
               op_d      = req_op[gnt_idx*OP_SIZE +: OP_SIZE];
               a_d       = req_a[gnt_idx*WORD_SIZE +: WORD_SIZE];
               b_d       = req_b[gnt_idx*WORD_SIZE +: WORD_SIZE];
               state_d   = EXEC;
            end
         end
         EXEC: begin
            data_d          = res;
            flags_d[FLAG_Z] = res == '0;
            flags_d[FLAG_N] = res[WORD_SIZE-1];
            flags_d[FLAG_C] = alu_c;
            flags_d[FLAG_V] = div0;
            state_d         = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               last_d  = id_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // no grant while reset is held, even though state reads IDLE
      if (rst) req_ready = '0;
   end

   // state and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= ID_W'(NUM_REQ - 1);
         id_q    <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         data_q  <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         data_q  <= data_d;
         flags_q <= flags_d;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors plus a transaction-level
// reference model compared against the DUT every cycle.
module tb_alu_arbiter;

   localparam int W   = 16;
   localparam int OPW = 3;
   localparam int NR  = 2;
   localparam int IDW = 1;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR*OPW-1:0] req_op;
   logic [NR*W-1:0]   req_a;
   logic [NR*W-1:0]   req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [W-1:0]      rsp_data;
   logic [3:0]        rsp_flags;
   logic              busy;

   int checks = 0;
   int errors = 0;
   bit started = 1'b0;
   int hs_ids[$];

   // model state: an operation is pending from accept until its
   // response handshake; m_stage marks the response as ready
   bit          m_pend;
   bit          m_stage;
   int          m_last;
   int          m_id;
   logic [19:0] m_exp;

   alu_arbiter #(
      .WORD_SIZE(W), .OP_SIZE(OPW), .NUM_REQ(NR), .ID_W(IDW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_flags (rsp_flags),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic int pick_ref(input logic [NR-1:0] v,
                                   input int last);
      for (int k = 1; k <= NR; k++)
         if (v[(last + k) % NR]) return (last + k) % NR;
      return -1;
   endfunction

   // returns {V, C, N, Z, result}
   function automatic logic [19:0] alu_ref(input logic [2:0] op,
                                           input logic [15:0] a,
                                           input logic [15:0] b);
      longint unsigned ua, ub, full;
      logic [15:0] r;
      logic c, v;
      ua = a; ub = b; c = 1'b0; v = 1'b0; r = '0; full = 0;
      case (op)
         3'd0: begin full = ua + ub; r = full[15:0]; c = full > 65535; end
         3'd1: begin r = a - b; c = ua < ub; end
         3'd2: r = ~a;
         3'd3: r = a & b;
         3'd4: r = a | b;
         3'd5: r = a ^ b;
         3'd6: begin full = ua * ub; r = full[15:0]; c = full > 65535; end
         3'd7: begin
            if (ub == 0) begin r = 16'hFFFF; v = 1'b1; end
            else begin full = ua / ub; r = full[15:0]; end
         end
         default: r = '0;
      endcase
      return {v, c, r[15], r == 16'h0, r};
   endfunction

   function automatic logic [19:0] exp_of(input int g);
      return alu_ref(req_op[g*OPW +: OPW], req_a[g*W +: W],
                     req_b[g*W +: W]);
   endfunction

   function automatic logic [NR-1:0] exp_ready();
      logic [NR-1:0] r;
      int g;
      r = '0;
      if (!rst && !m_pend) begin
         g = pick_ref(req_valid, m_last);
         if (g >= 0) r[g] = 1'b1;
      end
      return r;
   endfunction

   // transaction-level model update
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pend  <= 1'b0;
         m_stage <= 1'b0;
         m_last  <= NR - 1;
      end else if (!m_pend) begin
         if (pick_ref(req_valid, m_last) >= 0) begin
            m_pend  <= 1'b1;
            m_stage <= 1'b0;
            m_id    <= pick_ref(req_valid, m_last);
            m_exp   <= exp_of(pick_ref(req_valid, m_last));
         end
      end else if (!m_stage) begin
         m_stage <= 1'b1;
      end else if (rsp_ready) begin
         m_pend  <= 1'b0;
         m_stage <= 1'b0;
         m_last  <= m_id;
      end
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (started) begin
         chk("req_ready", req_ready, exp_ready());
         chk("onehot", $countones(req_ready) <= 1, 1);
         chk("rsp_valid", rsp_valid, m_pend && m_stage);
         chk("busy", busy, m_pend);
         if (m_pend && m_stage) begin
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_data", rsp_data, m_exp[15:0]);
            chk("rsp_flags", rsp_flags, m_exp[19:16]);
         end
         if (rsp_valid && rsp_ready && !rst)
            hs_ids.push_back(int'(rsp_id));
      end
   end

   task automatic run_op(input int r, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] xd, input logic [3:0] xf,
                         input int hold, input string nm);
      bit got;
      rsp_ready            = (hold == 0);
      req_op[r*OPW +: OPW] = op;
      req_a[r*W +: W]      = a;
      req_b[r*W +: W]      = b;
      req_valid[r]         = 1'b1;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if (req_ready[r]) got = 1'b1;
      end
      chk({nm, "_accept"}, got, 1);
      @(posedge clk);
      #1 req_valid[r] = 1'b0;
      @(negedge clk);
      chk({nm, "_exec_valid"}, rsp_valid, 0);
      @(negedge clk);
      chk({nm, "_valid"}, rsp_valid, 1);
      chk({nm, "_id"}, rsp_id, r);
      chk({nm, "_data"}, rsp_data, xd);
      chk({nm, "_flags"}, rsp_flags, xf);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({nm, "_hold_valid"}, rsp_valid, 1);
         chk({nm, "_hold_data"}, rsp_data, xd);
         chk({nm, "_hold_flags"}, rsp_flags, xf);
         chk({nm, "_hold_ready"}, req_ready, 0);
         chk({nm, "_hold_busy"}, busy, 1);
      end
      if (hold > 0) begin
         @(posedge clk);
         #1 rsp_ready = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit got;
      rst       = 1'b1;
      req_valid = '0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      @(posedge clk);
      started = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_flags", rsp_flags, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 0);
      rst = 1'b0;

      run_op(0, 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b0101, 0, "add");
      run_op(1, 3'd7, 16'h0010, 16'h0000, 16'hFFFF, 4'b1010, 0, "div0");
      run_op(0, 3'd1, 16'h0003, 16'h0005, 16'hFFFE, 4'b0110, 0, "sub");
      run_op(1, 3'd6, 16'h0100, 16'h0100, 16'h0000, 4'b0101, 4, "mul");

      // both requesters valid continuously for six operations
      rsp_ready = 1'b1;
      req_op    = {3'd4, 3'd3};
      req_a     = {16'h1200, 16'h0F0F};
      req_b     = {16'h0034, 16'h00FF};
      hs_ids.delete();
      req_valid = 2'b11;
      for (int c = 0; c < 100 && hs_ids.size() < 6; c++) begin
         @(negedge clk);
         #1;
      end
      @(posedge clk);
      #1 req_valid = '0;
      chk("rr_count", hs_ids.size(), 6);
      for (int i = 0; i < 6 && i < hs_ids.size(); i++)
         chk("rr_id", hs_ids[i], i % 2);

      // reset during EXEC with requester 1 still pending
      req_op    = {3'd5, 3'd2};
      req_a     = {16'hAAAA, 16'h00F0};
      req_b     = {16'h5555, 16'h0000};
      req_valid = 2'b11;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if (req_ready[0]) got = 1'b1;
      end
      chk("rst_mid_accept", got, 1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_valid", rsp_valid, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_ready", req_ready, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      hs_ids.delete();
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if (req_ready != '0) got = 1'b1;
      end
      chk("post_rst_first_grant", req_ready, 2'b01);
      @(posedge clk);
      #1 req_valid = '0;
      for (int c = 0; c < 20 && hs_ids.size() < 1; c++) begin
         @(negedge clk);
         #1;
      end
      chk("post_rst_rsp_count", hs_ids.size(), 1);
      chk("post_rst_rsp_id", hs_ids.size() > 0 ? hs_ids[0] : 99, 0);
      repeat (4) @(posedge clk);
      #1;
      chk("final_idle_busy", busy, 0);
      chk("final_idle_valid", rsp_valid, 0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
